// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: drives the butterfly control bus through LOAD/COMPUTE/WRITE for every stage of a frame.
// in_valid is sampled at the clock edge and its load shows up one cycle later; WRITE is a plain valid/ready handshake.
module fft_stage_sequencer #(
   parameter int no_point = 32,
   parameter int no_stage = $clog2(no_point),
   parameter int stage_w  = $clog2(no_stage) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               done,
   output logic [stage_w-1:0] stage_idx,
   output logic               data_in_en,
   output logic [1:0]         data_in_addr,
   output logic               w_addr,
   output logic               acu_enable,
   output logic               acu_load1,
   output logic               acu_load2,
   output logic               acu_cin1,
   output logic               acu_cin2,
   output logic               data_out_en,
   output logic               data_out_addr
);
   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;
   state_t     state;
   logic [1:0] step;
   logic [1:0] ck;
   logic [1:0] load_next;
   logic [4:0] vec;
   logic       last_stage;
   // ck is the compute step about to be presented: {w_addr, load1, load2, cin1, cin2}
   always_comb begin
      ck = (state == COMPUTE) ? step + 2'd1 : 2'd0;
      vec = (ck == 2'd0) ? 5'b01100 : (ck == 2'd1) ? 5'b10010 : (ck == 2'd2) ? 5'b00000 : 5'b00011;
      load_next = step + {1'b0, data_in_en};
      last_stage = stage_idx == stage_w'(no_stage - 1);
   end
   always_ff @(posedge clk) begin
      done <= 1'b0;
      data_in_en <= 1'b0;
      data_in_addr <= 2'd0;
      acu_enable <= 1'b0;
      {w_addr, acu_load1, acu_load2, acu_cin1, acu_cin2} <= 5'd0;
      data_out_en <= 1'b0;
      data_out_addr <= 1'b0;
      if (!rst) begin
         state <= IDLE;
         step <= 2'd0;
         stage_idx <= '0;
         busy <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= LOAD;
               step <= 2'd0;
               stage_idx <= '0;
               busy <= 1'b1;
               data_in_en <= in_valid;
            end
            LOAD: if (data_in_en && step == 2'd3) begin
               state <= COMPUTE;
               step <= 2'd0;
               acu_enable <= 1'b1;
               {w_addr, acu_load1, acu_load2, acu_cin1, acu_cin2} <= vec;
            end else begin
               step <= load_next;
               data_in_addr <= load_next;
               data_in_en <= in_valid;
            end
            COMPUTE: if (step == 2'd3) begin
               state <= WRITE;
               step <= 2'd0;
               data_out_en <= 1'b1;
            end else begin
               step <= step + 2'd1;
               acu_enable <= 1'b1;
               {w_addr, acu_load1, acu_load2, acu_cin1, acu_cin2} <= vec;
            end
            WRITE: begin
               data_out_en <= 1'b1;
               data_out_addr <= step[0];
               if (out_ready && !step[0]) begin
                  step <= 2'd1;
                  data_out_addr <= 1'b1;
               end else if (out_ready && !last_stage) begin
                  state <= LOAD;
                  step <= 2'd0;
                  stage_idx <= stage_idx + stage_w'(1);
                  data_out_en <= 1'b0;
                  data_out_addr <= 1'b0;
                  data_in_en <= in_valid;
               end else if (out_ready) begin
                  state <= DONE;
                  step <= 2'd0;
                  busy <= 1'b0;
                  done <= 1'b1;
                  data_out_en <= 1'b0;
                  data_out_addr <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               stage_idx <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed scenarios for fft_stage_sequencer at no_point=32, cycle-exact bus checks.
module tb_fft_stage_sequencer;
   logic       clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic       busy, done, data_in_en, w_addr, acu_enable, acu_load1, acu_load2, acu_cin1, acu_cin2;
   logic       data_out_en, data_out_addr;
   logic [3:0] stage_idx;
   logic [1:0] data_in_addr;
   logic [16:0] obs, exp_v;
   int passed = 0, total = 0;

   fft_stage_sequencer #(.no_point(32)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .stage_idx(stage_idx), .data_in_en(data_in_en),
      .data_in_addr(data_in_addr), .w_addr(w_addr), .acu_enable(acu_enable),
      .acu_load1(acu_load1), .acu_load2(acu_load2), .acu_cin1(acu_cin1), .acu_cin2(acu_cin2),
      .data_out_en(data_out_en), .data_out_addr(data_out_addr)
   );

   always #5 clk = ~clk;

   assign obs = {busy, done, stage_idx, data_in_en, data_in_addr, w_addr, acu_enable,
                 acu_load1, acu_load2, acu_cin1, acu_cin2, data_out_en, data_out_addr};

   // Unstalled frame: cycle c after the start cycle; stage = (c-1)/10, 4 load, 4 compute, 2 write.
   function automatic logic [16:0] nom(input int c);
      int s, p, q;
      logic acu;
      if (c < 1 || c > 51) return '0;
      if (c == 51) return {2'b01, 4'd4, 11'd0};
      s = (c - 1) / 10;
      p = (c - 1) % 10;
      q = p - 4;
      acu = (p >= 4) && (p <= 7);
      return {1'b1, 1'b0, 4'(s), p < 4, (p < 4) ? 2'(p) : 2'd0, acu && q == 1, acu,
              acu && q == 0, acu && q == 0, acu && (q == 1 || q == 3), acu && q == 3, p >= 8, p == 9};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      start = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (obs !== 17'd0) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, obs, 17'd0);
         else passed++;
      end
      rst = 1'b1;
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if (obs !== 17'd0) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs, 17'd0);
         else passed++;
      end
   endtask

   task automatic test_nominal;
      start = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 1; c <= 53; c++) begin
         tick();
         start = 1'b0;
         exp_v = nom(c);
         total++;
         if (obs !== exp_v) $display("FAIL nominal cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else passed++;
      end
   endtask

   task automatic test_load_stall;
      start = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 1; c <= 56; c++) begin
         tick();
         start = 1'b0;
         exp_v = (c <= 2) ? nom(c) : (c <= 5) ? (nom(3) & ~17'h00400) : nom(c - 3);
         total++;
         if (obs !== exp_v) $display("FAIL load_stall cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else passed++;
         in_valid = !(c >= 2 && c <= 4);
      end
      in_valid = 1'b1;
   endtask

   task automatic test_write_stall;
      start = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 1; c <= 56; c++) begin
         tick();
         start = 1'b0;
         exp_v = (c <= 50) ? nom(c) : (c <= 52) ? nom(50) : nom(c - 2);
         total++;
         if (obs !== exp_v) $display("FAIL write_stall cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else passed++;
         out_ready = !(c == 50 || c == 51);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid;
      start = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 1; c <= 26; c++) begin
         tick();
         start = 1'b0;
         exp_v = nom(c);
         total++;
         if (obs !== exp_v) $display("FAIL mid_pre cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else passed++;
      end
      rst = 1'b0;
      tick();
      total++;
      if (obs !== 17'd0) $display("FAIL mid_reset got=%h exp=%h", obs, 17'd0);
      else passed++;
      rst = 1'b1;
      for (int c = 28; c <= 60; c++) begin
         tick();
         total++;
         if (obs !== 17'd0) $display("FAIL mid_after cyc=%0d got=%h exp=%h", c, obs, 17'd0);
         else passed++;
      end
   endtask

   task automatic test_start_ignored;
      start = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 1; c <= 58; c++) begin
         tick();
         exp_v = nom(c);
         total++;
         if (obs !== exp_v) $display("FAIL start_ignored cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else passed++;
         start = (c == 20 || c == 35 || c == 51);
      end
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_load_stall();
      test_write_stall();
      test_reset_mid();
      test_nominal();
      test_start_ignored();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control sequencer that drives the shared butterfly control bus of one FFT stage array: data_in_en/data_in_addr, w_addr, acu_*, data_out_en/data_out_addr.
- Sits between the FFT top-level and the stage units.
- Runs log2(no_point) stages per frame. Each stage is a fixed microsequence: LOAD (4 words), COMPUTE (4 steps), WRITE (2 words).
- Has a start/busy/done handshake plus in_valid/out_ready flow control.

Parameters:
- no_point, 32, FFT size; power of two, 4..1024.
- no_stage, $clog2(no_point), number of stages per frame.
- stage_w, $clog2(no_stage)+1, width of stage_idx.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- start  input  1  frame start request; sampled only in IDLE.
- in_valid  input  1  stage input data valid; advances LOAD.
- out_ready  input  1  downstream accepts stage output; advances WRITE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last WRITE of the last stage.
- stage_idx  output  stage_w  current stage, 0..no_stage-1.
- data_in_en  output  1  load butterfly input register.
- data_in_addr  output  2  input register select: 0=in1_real, 1=in1_imag, 2=in2_real, 3=in2_imag.
- w_addr  output  1  twiddle part select: 0=real, 1=imag.
- acu_enable  output  1  accumulators active.
- acu_load1, acu_load2  output  1  accumulator 1/2 load (overwrite) instead of accumulate.
- acu_cin1, acu_cin2  output  1  accumulator 1/2 carry-in (subtract).
- data_out_en  output  1  drive butterfly result.
- data_out_addr  output  1  0=out1, 1=out2.

Behaviour:
- States: IDLE, LOAD, COMPUTE, WRITE, DONE.
- A 2-bit step counter indexes steps within LOAD, COMPUTE and WRITE.
- All outputs are registered.
- Reset (rst=0 at a clock edge), from any state including mid-frame:
  - next state IDLE, step=0, stage_idx=0.
  - every output 0 in the following cycle.
  - No partial-frame completion; done is not pulsed.
- IDLE: outputs 0. If start=1, go to LOAD with step 0, stage_idx 0, busy=1 from the next cycle.
- LOAD:
  - data_in_en = in_valid; data_in_addr = step.
  - step advances only on a cycle with in_valid=1.
  - When in_valid=0: data_in_en=0, data_in_addr is held, no advance.
  - After the step-3 transfer, go to COMPUTE with step 0.
- COMPUTE: acu_enable=1; no stalls, exactly 4 cycles. Control vector (w_addr, load1, load2, cin1, cin2) per step:
  - step 0: (0,1,1,0,0)
  - step 1: (1,0,0,1,0)
  - step 2: (0,0,0,0,0)
  - step 3: (0,0,0,1,1)
  - Then go to WRITE with step 0.
- WRITE:
  - data_out_en=1; data_out_addr = step[0].
  - step advances only when out_ready=1; data_out_en stays 1 while stalled.
  - After the step-1 transfer:
    - if stage_idx < no_stage-1: stage_idx+1, go to LOAD.
    - otherwise go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, stage_idx held, then IDLE.
- start while busy, or in DONE, is ignored. No queued frame.
- Outside its own state, each control output is 0 (acu_* only in COMPUTE, data_out_* only in WRITE, data_in_* only in LOAD).
- Latency with no stalls:
  - 10 cycles per stage.
  - done asserted 10*no_stage+1 cycles after the start cycle (51 for no_point=32).
  - Each in_valid=0 or out_ready=0 cycle in a handshaking step adds exactly 1 cycle.
- stage_idx wraps only via IDLE; it never exceeds no_stage-1.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 → all outputs 0, busy=0; after release with start=0 the block stays IDLE.
- Nominal frame (no_point=32): start pulse at cycle 0, in_valid=1, out_ready=1.
  - busy=1 on cycles 1..50; done=1 only on cycle 51.
  - stage_idx steps 0→4 every 10 cycles.
  - COMPUTE vectors exactly as tabled in each stage.
- LOAD stall: drop in_valid for 3 cycles at data_in_addr=2 → data_in_en=0 and addr held at 2 for those cycles; done delayed to cycle 54.
- WRITE stall: out_ready=0 for 2 cycles at data_out_addr=1 in stage 4 → data_out_en=1 and addr held at 1; done delayed by exactly 2.
- Reset mid-COMPUTE of stage 2 → next cycle all outputs 0, stage_idx=0, no done pulse; a subsequent start runs a full 51-cycle frame.
- start re-asserted during busy and in the DONE cycle → ignored; no second frame starts, busy falls with done.
